code_lock_fsm: RTL and testbench

- Parametrised successor to the team's fixed 3-step serial lock.
- Accepts a code of CODE_LEN symbols, each SYM_W bits wide, one symbol per key_valid strobe.
- Opens for a bounded time, counts failed attempts, and enters a timed lockout after MAX_FAIL failures.
- Sits between the keypad scanner/debouncer (upstream) and the actuator driver (downstream).

---
 rtl/code_lock_pkg.sv | 18 +
 rtl/code_lock_fsm_if.sv | 44 ++++
 rtl/lock_timer.sv | 35 +++
 rtl/code_lock_fsm.sv | 172 +++++++++++++++++
 tb/tb_code_lock_fsm.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/code_lock_pkg.sv
// Shared types and helpers for the parametrised serial code lock.
package code_lock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTRY   = 2'd1,
        OPEN    = 2'd2,
        LOCKOUT = 2'd3
    } lock_state_t;

    // Counter/index width that never collapses to zero bits.
    function automatic int unsigned width_of(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/code_lock_fsm_if.sv
// Keypad-side and actuator-side signals of the code lock.
// CODE_LOCK_PROGRAM_EN adds the prog_valid/prog_code code-programming pair.
interface code_lock_fsm_if #(
    parameter int unsigned SYM_W    = 4,
    parameter int unsigned CODE_LEN = 4,
    parameter int unsigned MAX_FAIL = 3
) ();
    import code_lock_pkg::*;

    localparam int unsigned FCW = width_of(MAX_FAIL + 1);
    localparam int unsigned IW  = width_of(CODE_LEN);

    logic                key_valid;
    logic [SYM_W-1:0]    key_sym;
    logic                relock;
    logic                unlocked;
    logic                lockout;
    logic                fail;
    logic [FCW-1:0]      fail_count;
    logic [IW-1:0]       entry_idx;
`ifdef CODE_LOCK_PROGRAM_EN
    logic                        prog_valid;
    logic [SYM_W*CODE_LEN-1:0]   prog_code;

    modport master (
        output key_valid, key_sym, relock, prog_valid, prog_code,
        input  unlocked, lockout, fail, fail_count, entry_idx
    );
    modport slave (
        input  key_valid, key_sym, relock, prog_valid, prog_code,
        output unlocked, lockout, fail, fail_count, entry_idx
    );
`else
    modport master (
        output key_valid, key_sym, relock,
        input  unlocked, lockout, fail, fail_count, entry_idx
    );
    modport slave (
        input  key_valid, key_sym, relock,
        output unlocked, lockout, fail, fail_count, entry_idx
    );
`endif

endinterface

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the open, lockout and entry-timeout phases.
module lock_timer #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (value_q != '0) begin
            value_d = value_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value   = value_q;
    assign expired = (value_q == '0);

endmodule

// File: rtl/code_lock_fsm.sv
// Serial code lock: symbol entry, bounded open window, failure count and timed lockout.
// Optional code programming while open is enabled by CODE_LOCK_PROGRAM_EN.
module code_lock_fsm
    import code_lock_pkg::*;
#(
    parameter int unsigned                   SYM_W          = 4,
    parameter int unsigned                   CODE_LEN       = 4,
    parameter logic [SYM_W*CODE_LEN-1:0]     DEFAULT_CODE   = 16'h1234,
    parameter int unsigned                   MAX_FAIL       = 3,
    parameter int unsigned                   OPEN_CYCLES    = 8,
    parameter int unsigned                   LOCKOUT_CYCLES = 32,
    parameter int unsigned                   TIMEOUT_CYCLES = 64
) (
    input logic           clk,
    input logic           reset,
    code_lock_fsm_if.slave bus
);

    localparam int unsigned CW   = SYM_W * CODE_LEN;
    localparam int unsigned FCW  = width_of(MAX_FAIL + 1);
    localparam int unsigned IW   = width_of(CODE_LEN);
    localparam int unsigned TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES)
        ? ((OPEN_CYCLES > TIMEOUT_CYCLES) ? OPEN_CYCLES : TIMEOUT_CYCLES)
        : ((LOCKOUT_CYCLES > TIMEOUT_CYCLES) ? LOCKOUT_CYCLES : TIMEOUT_CYCLES);
    localparam int unsigned TW   = width_of(TMAX + 1);

    lock_state_t    state_q, state_d;
    logic [IW-1:0]  entry_idx_q, entry_idx_d;
    logic [FCW-1:0] fail_count_q, fail_count_d;
    logic           mismatch_q, mismatch_d;
    logic           fail_q, fail_d;
    logic           unlocked_q, lockout_q;
    logic           miss, is_last, prog_hit;
    logic           tmr_load, tmr_expired;
    logic [TW-1:0]  tmr_load_val, unused_tmr_value;
    logic [CW-1:0]  code_q;

    logic [CODE_LEN-1:0][SYM_W-1:0] code_syms;
    logic [SYM_W-1:0]               exp_sym;
    logic [IW-1:0]                  sym_pos;

`ifdef CODE_LOCK_PROGRAM_EN
    logic [CW-1:0] code_d;
    assign prog_hit = bus.prog_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code_q <= DEFAULT_CODE;
        end else begin
            code_q <= code_d;
        end
    end
`else
    assign prog_hit = 1'b0;
    assign code_q   = DEFAULT_CODE;
`endif

    // Symbol 0 (entered first) sits in the most significant slot.
    assign code_syms = code_q;
    assign sym_pos   = IW'(CODE_LEN - 1) - entry_idx_q;
    assign exp_sym   = code_syms[sym_pos];
    assign is_last   = (entry_idx_q == IW'(CODE_LEN - 1));
    assign miss      = mismatch_q | (bus.key_sym != exp_sym);

    lock_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .value    (unused_tmr_value),
        .expired  (tmr_expired)
    );

    // Timer loads N-1 so a phase spans exactly N cycles before expiry is seen.
    always_comb begin
        state_d      = state_q;
        entry_idx_d  = entry_idx_q;
        mismatch_d   = mismatch_q;
        fail_count_d = fail_count_q;
        fail_d       = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
`ifdef CODE_LOCK_PROGRAM_EN
        code_d       = code_q;
`endif
        unique case (state_q)
            IDLE, ENTRY: begin
                if (bus.key_valid) begin
                    if (is_last) begin
                        entry_idx_d = '0;
                        mismatch_d  = 1'b0;
                        if (!miss) begin
                            state_d      = OPEN;
                            fail_count_d = '0;
                            tmr_load     = 1'b1;
                            tmr_load_val = TW'(OPEN_CYCLES - 1);
                        end else begin
                            fail_d = 1'b1;
                            if (int'(fail_count_q) + 1 < int'(MAX_FAIL)) begin
                                fail_count_d = fail_count_q + FCW'(1);
                                state_d      = IDLE;
                            end else begin
                                fail_count_d = FCW'(MAX_FAIL);
                                state_d      = LOCKOUT;
                                tmr_load     = 1'b1;
                                tmr_load_val = TW'(LOCKOUT_CYCLES - 1);
                            end
                        end
                    end else begin
                        entry_idx_d  = entry_idx_q + IW'(1);
                        mismatch_d   = miss;
                        state_d      = ENTRY;
                        tmr_load     = 1'b1;
                        tmr_load_val = TW'(TIMEOUT_CYCLES - 1);
                    end
                end else if (state_q == ENTRY && tmr_expired) begin
                    state_d     = IDLE;
                    entry_idx_d = '0;
                    mismatch_d  = 1'b0;
                end
            end
            OPEN: begin
                if (prog_hit) begin
`ifdef CODE_LOCK_PROGRAM_EN
                    code_d = bus.prog_code;
`endif
                    tmr_load     = 1'b1;
                    tmr_load_val = TW'(OPEN_CYCLES - 1);
                end
                if (bus.relock || (tmr_expired && !prog_hit)) begin
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                if (tmr_expired) begin
                    state_d      = IDLE;
                    fail_count_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            entry_idx_q  <= '0;
            fail_count_q <= '0;
            mismatch_q   <= 1'b0;
            fail_q       <= 1'b0;
            unlocked_q   <= 1'b0;
            lockout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            entry_idx_q  <= entry_idx_d;
            fail_count_q <= fail_count_d;
            mismatch_q   <= mismatch_d;
            fail_q       <= fail_d;
            unlocked_q   <= (state_d == OPEN);
            lockout_q    <= (state_d == LOCKOUT);
        end
    end

    assign bus.unlocked   = unlocked_q;
    assign bus.lockout    = lockout_q;
    assign bus.fail       = fail_q;
    assign bus.fail_count = fail_count_q;
    assign bus.entry_idx  = entry_idx_q;

endmodule

// File: tb/tb_code_lock_fsm.sv
// Directed bench for code_lock_fsm; programming steps run when CODE_LOCK_PROGRAM_EN is defined.
module tb_code_lock_fsm;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    code_lock_fsm_if #(.SYM_W(4), .CODE_LEN(4), .MAX_FAIL(3)) bus ();

    code_lock_fsm #(
        .SYM_W          (4),
        .CODE_LEN       (4),
        .DEFAULT_CODE   (16'h1234),
        .MAX_FAIL       (3),
        .OPEN_CYCLES    (8),
        .LOCKOUT_CYCLES (32),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic check_outs(input string tag, input logic unl, input logic lko,
                              input logic fl, input logic [1:0] fc, input logic [1:0] idx);
        check({tag, ".unlocked"},   32'(bus.unlocked),   32'(unl));
        check({tag, ".lockout"},    32'(bus.lockout),    32'(lko));
        check({tag, ".fail"},       32'(bus.fail),       32'(fl));
        check({tag, ".fail_count"}, 32'(bus.fail_count), 32'(fc));
        check({tag, ".entry_idx"},  32'(bus.entry_idx),  32'(idx));
    endtask

    task automatic key(input logic [3:0] sym);
        bus.key_valid = 1'b1;
        bus.key_sym   = sym;
        tick();
        bus.key_valid = 1'b0;
    endtask

    task automatic code4(input logic [15:0] c);
        key(c[15:12]);
        key(c[11:8]);
        key(c[7:4]);
        key(c[3:0]);
    endtask

    task automatic do_relock();
        bus.relock = 1'b1;
        tick();
        bus.relock = 1'b0;
    endtask

    initial begin
        bus.key_valid = 1'b0;
        bus.key_sym   = '0;
        bus.relock    = 1'b0;
`ifdef CODE_LOCK_PROGRAM_EN
        bus.prog_valid = 1'b0;
        bus.prog_code  = '0;
`endif
        reset = 1'b0;
        repeat (2) tick();
        check_outs("reset", 0, 0, 0, 2'd0, 2'd0);
        reset = 1'b1;
        tick();

        // Correct code: open for exactly 8 cycles, no fail pulse.
        key(4'h1); check("t1_idx1", 32'(bus.entry_idx), 32'd1);
        key(4'h2); check("t1_idx2", 32'(bus.entry_idx), 32'd2);
        key(4'h3); check("t1_idx3", 32'(bus.entry_idx), 32'd3);
        check("t1_not_yet", 32'(bus.unlocked), 32'd0);
        key(4'h4); check_outs("t1_open", 1, 0, 0, 2'd0, 2'd0);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("t1_hold", 32'(bus.unlocked), 32'd1);
            check("t1_nofail", 32'(bus.fail), 32'd0);
        end
        tick(); check("t1_close", 32'(bus.unlocked), 32'd0);

        // Single wrong code.
        code4(16'h1934); check_outs("t2_fail", 0, 0, 1, 2'd1, 2'd0);
        tick();          check_outs("t2_after", 0, 0, 0, 2'd1, 2'd0);

        // Reach lockout; correct code ignored while locked.
        code4(16'h1934); check_outs("t3_fail2", 0, 0, 1, 2'd2, 2'd0);
        code4(16'h1934); check_outs("t3_lock", 0, 1, 1, 2'd3, 2'd0);
        code4(16'h1234); check_outs("t3_ignored", 0, 1, 0, 2'd3, 2'd0);
        repeat (27) tick();
        check("t3_lock_last", 32'(bus.lockout), 32'd1);
        tick(); check_outs("t3_exit", 0, 0, 0, 2'd0, 2'd0);
        code4(16'h1234); check("t3_unlock", 32'(bus.unlocked), 32'd1);

        // Relock on third open cycle.
        tick(); tick(); check("t5_open3", 32'(bus.unlocked), 32'd1);
        do_relock(); check_outs("t5_relock", 0, 0, 0, 2'd0, 2'd0);
        do_relock(); check_outs("t5_relock_idle", 0, 0, 0, 2'd0, 2'd0);

        // Entry timeout is not a failure.
        code4(16'h1934); tick();
        key(4'h1); key(4'h2);
        repeat (63) tick();
        check("t4_pre_timeout", 32'(bus.entry_idx), 32'd2);
        tick(); check_outs("t4_timeout", 0, 0, 0, 2'd1, 2'd0);

        // Key on the expiry cycle wins over the timeout.
        key(4'h1); key(4'h2);
        repeat (63) tick();
        key(4'h3); check("t4_key_wins", 32'(bus.entry_idx), 32'd3);
        key(4'h4); check_outs("t4_open", 1, 0, 0, 2'd0, 2'd0);
        do_relock();

        // Asynchronous reset mid-entry.
        code4(16'h1934); tick();
        key(4'h1); key(4'h2);
        check_outs("t6_pre_reset", 0, 0, 0, 2'd1, 2'd2);
        #2 reset = 1'b0;
        #1 check_outs("t6_reset", 0, 0, 0, 2'd0, 2'd0);
        reset = 1'b1;
        tick();
        code4(16'h1234); check_outs("t6_reopen", 1, 0, 0, 2'd0, 2'd0);
        do_relock();

`ifdef CODE_LOCK_PROGRAM_EN
        code4(16'h1234); check("p_open", 32'(bus.unlocked), 32'd1);
        bus.prog_valid = 1'b1;
        bus.prog_code  = 16'hA5C3;
        tick();
        bus.prog_valid = 1'b0;
        check("p_still_open", 32'(bus.unlocked), 32'd1);
        do_relock();
        code4(16'h1234); check_outs("p_old_fails", 0, 0, 1, 2'd1, 2'd0);
        tick();
        code4(16'hA5C3); check_outs("p_new_opens", 1, 0, 0, 2'd0, 2'd0);
        do_relock();
        bus.prog_valid = 1'b1;
        bus.prog_code  = 16'h1234;
        tick();
        bus.prog_valid = 1'b0;
        code4(16'h1234); check_outs("p_idle_ignored", 0, 0, 1, 2'd1, 2'd0);
        tick();
        code4(16'hA5C3); check("p_kept", 32'(bus.unlocked), 32'd1);
        do_relock();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
